fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter sequencer: arms on Start, runs sequential/branch fetch until a
// halt word, and keeps saturating cycle and taken-branch counts per run.
module fetch_unit (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic [9:0]  StartAddr,
   input  logic [8:0]  Instruction,
   input  logic        BeqEn,
   input  logic        BtrEn,
   input  logic        Zero,
   input  logic        Flag,
   input  logic [9:0]  Target,
   output logic [9:0]  PC,
   output logic        Running,
   output logic        Done,
   output logic [15:0] CycleCt,
   output logic [7:0]  TakenCt
);

   localparam int unsigned AW = 10;
   localparam int unsigned IW = 9;
   localparam int unsigned CW = 16;
   localparam int unsigned TW = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Halt is any non-create word whose opcode nibble is all ones.
   localparam logic [IW-1:0] HALT_MASK = IW'(9'h1F0);
   localparam logic [IW-1:0] HALT_WORD = IW'(9'h0F0);

   logic [1:0]    state, state_nx;
   logic [AW-1:0] pc_nx;
   logic [CW-1:0] cyc_nx;
   logic [TW-1:0] tak_nx;
   logic          halt, taken;

   assign halt  = (Instruction & HALT_MASK) == HALT_WORD;
   assign taken = (BeqEn & Zero) | (BtrEn & Flag);

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state   <= S_IDLE;
         PC      <= '0;
         CycleCt <= '0;
         TakenCt <= '0;
         Running <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state   <= state_nx;
         PC      <= pc_nx;
         CycleCt <= cyc_nx;
         TakenCt <= tak_nx;
         Running <= (state_nx == S_RUN);
         Done    <= (state_nx == S_DONE);
      end
   end

   // Next-state and register update; Start dominates in every state.
   always_comb begin
      state_nx = state;
      pc_nx    = PC;
      cyc_nx   = CycleCt;
      tak_nx   = TakenCt;
      case (state)
         S_IDLE, S_DONE: begin
            if (Start) begin
               state_nx = S_ARMED;
               pc_nx    = StartAddr;
               cyc_nx   = '0;
               tak_nx   = '0;
            end
         end
         S_ARMED: begin
            cyc_nx = '0;
            tak_nx = '0;
            if (Start) pc_nx = StartAddr;
            else       state_nx = S_RUN;
         end
         S_RUN: begin
            if (Start) begin
               state_nx = S_ARMED;
               pc_nx    = StartAddr;
               cyc_nx   = '0;
               tak_nx   = '0;
            end else begin
               cyc_nx = (CycleCt == '1) ? CycleCt : CycleCt + CW'(1);
               if (halt) begin
                  state_nx = S_DONE;
               end else if (taken) begin
                  pc_nx  = Target;
                  tak_nx = (TakenCt == '1) ? TakenCt : TakenCt + TW'(1);
               end else begin
                  pc_nx = PC + AW'(1);
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-word programmable ROM model.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset, Start, BeqEn, BtrEn, Zero, Flag;
   logic [9:0]  StartAddr, Target;
   logic [8:0]  Instruction;
   logic [9:0]  PC;
   logic        Running, Done;
   logic [15:0] CycleCt;
   logic [7:0]  TakenCt;

   logic        sp_en;
   logic [9:0]  sp_pc;
   logic [8:0]  sp_word;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
      .Instruction(Instruction), .BeqEn(BeqEn), .BtrEn(BtrEn), .Zero(Zero),
      .Flag(Flag), .Target(Target), .PC(PC), .Running(Running), .Done(Done),
      .CycleCt(CycleCt), .TakenCt(TakenCt)
   );

   always #5 CLK = ~CLK;

   // ROM: one special word at sp_pc, everything else is a plain non-halt word.
   always_comb Instruction = (sp_en && PC == sp_pc) ? sp_word : 9'h000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic arm_run(input logic [9:0] addr);
      Start = 1'b1; StartAddr = addr;
      tick();
      Start = 1'b0;
      tick();
   endtask

   task automatic clr_br();
      BeqEn = 1'b0; BtrEn = 1'b0; Zero = 1'b0; Flag = 1'b0; Target = '0;
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; StartAddr = '0;
      sp_en = 1'b0; sp_pc = '0; sp_word = '0;
      clr_br();
      tick(); tick();
      check("rst_pc", 32'(PC), 32'h000);
      check("rst_run", 32'(Running), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_cyc", 32'(CycleCt), 32'd0);
      check("rst_tak", 32'(TakenCt), 32'd0);

      Reset = 1'b1;
      tick(); tick();
      check("idle_hold_pc", 32'(PC), 32'h000);
      check("idle_hold_run", 32'(Running), 32'd0);

      // Arm for three cycles then release.
      Start = 1'b1; StartAddr = 10'h010;
      tick();
      check("arm_pc", 32'(PC), 32'h010);
      check("arm_run", 32'(Running), 32'd0);
      tick(); tick();
      check("arm3_pc", 32'(PC), 32'h010);
      Start = 1'b0;
      tick();
      check("rel_pc", 32'(PC), 32'h010);
      check("rel_run", 32'(Running), 32'd1);
      check("rel_cyc", 32'(CycleCt), 32'd0);
      tick();
      check("seq1_pc", 32'(PC), 32'h011);
      check("seq1_cyc", 32'(CycleCt), 32'd1);
      tick();
      check("seq2_pc", 32'(PC), 32'h012);

      // Branch taken on BeqEn & Zero.
      arm_run(10'h020);
      BeqEn = 1'b1; Zero = 1'b1; Target = 10'h005;
      tick();
      check("beq_pc", 32'(PC), 32'h005);
      check("beq_tak", 32'(TakenCt), 32'd1);
      check("beq_cyc", 32'(CycleCt), 32'd1);
      clr_br();

      // Abort mid-run.
      Start = 1'b1; StartAddr = 10'h020;
      tick();
      check("abort_run", 32'(Running), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_pc", 32'(PC), 32'h020);
      check("abort_cyc", 32'(CycleCt), 32'd0);
      check("abort_tak", 32'(TakenCt), 32'd0);
      Start = 1'b0;
      tick();
      BeqEn = 1'b1; Zero = 1'b0; Target = 10'h005;
      tick();
      check("beq_nt_pc", 32'(PC), 32'h021);
      check("beq_nt_tak", 32'(TakenCt), 32'd0);
      BtrEn = 1'b1; Flag = 1'b1;
      tick();
      check("btr_pc", 32'(PC), 32'h005);
      check("btr_tak", 32'(TakenCt), 32'd1);
      clr_br();

      // Last StartAddr while armed wins.
      Start = 1'b1; StartAddr = 10'h100;
      tick();
      StartAddr = 10'h2AA;
      tick();
      Start = 1'b0;
      tick();
      check("lastwin_pc", 32'(PC), 32'h2AA);

      // Halt at 0x030 after two sequential words.
      sp_en = 1'b1; sp_pc = 10'h030; sp_word = 9'h0F0;
      arm_run(10'h02E);
      tick(); tick();
      check("pre_halt_pc", 32'(PC), 32'h030);
      tick();
      check("halt_done", 32'(Done), 32'd1);
      check("halt_run", 32'(Running), 32'd0);
      check("halt_pc", 32'(PC), 32'h030);
      check("halt_cyc", 32'(CycleCt), 32'd3);
      tick();
      check("done_hold_pc", 32'(PC), 32'h030);
      check("done_hold_cyc", 32'(CycleCt), 32'd3);
      check("done_hold", 32'(Done), 32'd1);
      Start = 1'b1; StartAddr = 10'h040;
      tick();
      check("restart_done", 32'(Done), 32'd0);
      check("restart_pc", 32'(PC), 32'h040);
      check("restart_cyc", 32'(CycleCt), 32'd0);
      Start = 1'b0;

      // Halt beats branch.
      sp_pc = 10'h050;
      arm_run(10'h050);
      BeqEn = 1'b1; Zero = 1'b1; Target = 10'h005;
      tick();
      check("hprio_done", 32'(Done), 32'd1);
      check("hprio_pc", 32'(PC), 32'h050);
      check("hprio_tak", 32'(TakenCt), 32'd0);
      clr_br();

      // Start beats halt.
      arm_run(10'h050);
      Start = 1'b1; StartAddr = 10'h060;
      tick();
      check("sprio_done", 32'(Done), 32'd0);
      check("sprio_run", 32'(Running), 32'd0);
      check("sprio_pc", 32'(PC), 32'h060);
      Start = 1'b0;

      // Create word must not halt.
      sp_pc = 10'h070; sp_word = 9'h1F0;
      arm_run(10'h070);
      tick();
      check("create_run", 32'(Running), 32'd1);
      check("create_done", 32'(Done), 32'd0);
      check("create_pc", 32'(PC), 32'h071);
      sp_en = 1'b0;

      // Reset mid-run overrides Start.
      arm_run(10'h080);
      tick();
      Reset = 1'b0; Start = 1'b1; StartAddr = 10'h123;
      tick();
      check("rrun_pc", 32'(PC), 32'h000);
      check("rrun_run", 32'(Running), 32'd0);
      check("rrun_cyc", 32'(CycleCt), 32'd0);
      Reset = 1'b1; Start = 1'b0;
      tick(); tick();
      check("rrun_idle_pc", 32'(PC), 32'h000);
      check("rrun_idle_run", 32'(Running), 32'd0);

      // Wrap, then CycleCt and TakenCt saturation.
      arm_run(10'h3FE);
      check("wrap0", 32'(PC), 32'h3FE);
      tick();
      check("wrap1", 32'(PC), 32'h3FF);
      tick();
      check("wrap2", 32'(PC), 32'h000);
      tick();
      check("wrap3", 32'(PC), 32'h001);
      check("wrap_run", 32'(Running), 32'd1);
      check("wrap_cyc", 32'(CycleCt), 32'd3);
      repeat (65540) tick();
      check("cyc_sat", 32'(CycleCt), 32'hFFFF);
      check("cyc_sat_run", 32'(Running), 32'd1);
      BeqEn = 1'b1; Zero = 1'b1; Target = 10'h123;
      repeat (300) tick();
      check("tak_sat", 32'(TakenCt), 32'hFF);
      check("tak_sat_pc", 32'(PC), 32'h123);
      check("cyc_sat2", 32'(CycleCt), 32'hFFFF);
      clr_br();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
